matrix_ctrl_fsm: RTL and testbench
==================================

Name: matrix_ctrl_fsm

Overview:
Top-level control FSM of the matrix calculator. It sequences user input, random generation, storage, operand selection, compute and display. It drives one-cycle start strobes to those datapath blocks, runs the post-error countdown, and publishes the registered 4-bit state code that the LED status decoder consumes. State encoding is fixed: 0 IDLE, 1 MENU, 2 INPUT, 3 GEN, 4 DISPLAY, 5 COMPUTE, 6 ERROR, 7 STORE, 8 SELECT, 9 WAIT.

Parameters:
CLK_FREQ, 100_000_000, clock cycles per countdown second (prescaler terminal count); must be >= 2.
WAIT_SEC, 5, seconds spent in WAIT after an error; legal range 1..15.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
btn_confirm  input  1  debounced one-cycle confirm pulse
btn_back  input  1  debounced one-cycle back pulse
op_sel  input  2  menu choice sampled on confirm in MENU: 0 INPUT, 1 GEN, 2 DISPLAY, 3 SELECT
input_done  input  1  input block finished (pulse)
input_err  input  1  input out of range / bad dimension (pulse)
gen_done  input  1  generator finished (pulse)
store_done  input  1  store block finished (pulse)
store_full  input  1  store block has no free slot (pulse)
operands_ok  input  1  level; selected operands are dimension-compatible, sampled on confirm in SELECT
comp_done  input  1  compute finished (pulse)
comp_err  input  1  compute fault (pulse)
state  output  4  current state code
input_start, gen_start, disp_start, comp_start, store_start  output  1 each  one-cycle start strobes
countdown  output  4  remaining seconds while in WAIT, else 0
err_code  output  3  0 none, 1 input, 2 store full, 3 operand mismatch, 4 compute

Behaviour:
- Everything is registered. On rst: state=0, all strobes=0, countdown=0, err_code=0, prescaler=0, retry flag=0. rst has priority over all inputs, including in mid-WAIT.
- Transitions, evaluated in priority order error > done > back > confirm:
  - IDLE: confirm -> MENU.
  - MENU: confirm -> target selected by op_sel. back -> IDLE.
  - INPUT: input_err -> ERROR (code 1). input_done -> STORE. back -> MENU.
  - GEN: gen_done -> STORE. back -> MENU.
  - STORE: store_full -> ERROR (code 2). store_done -> MENU. back is ignored.
  - DISPLAY: back -> MENU. confirm -> MENU.
  - SELECT: confirm with operands_ok=1 -> COMPUTE. confirm with operands_ok=0 -> ERROR (code 3). back -> MENU.
  - COMPUTE: comp_err -> ERROR (code 4). comp_done -> DISPLAY. back is ignored.
  - ERROR: lasts exactly 1 cycle, then -> WAIT.
  - WAIT: counts down and ignores all buttons.
- Done and err pulses arriving outside their owning state are ignored.
- Strobes: each strobe is high for exactly the first cycle that state equals 2/3/4/5/7 (input/gen/disp/comp/store respectively). It is registered in the same edge as the state change. Re-entering a state re-fires its strobe.
- err_code is loaded on the edge that enters ERROR. It holds through WAIT and clears to 0 on the edge that leaves WAIT.
- Retry flag is set on entry to ERROR with code 3 or 4, and cleared otherwise.
- WAIT countdown:
  - Entering WAIT loads countdown=WAIT_SEC and prescaler=0.
  - The prescaler counts 0..CLK_FREQ-1. On wrap, countdown decrements.
  - When countdown==1 and the prescaler wraps: countdown becomes 0 and, on the same edge, state -> SELECT if the retry flag is set, else -> MENU.
  - Total WAIT residency is exactly WAIT_SEC*CLK_FREQ cycles.
- Outside WAIT, countdown=0 and the prescaler is held at 0.
- Undefined state codes 10..15 are illegal: recover to IDLE on the next edge with all outputs 0.

Test Plan:
(Bench uses CLK_FREQ=4, WAIT_SEC=3.)
1. Reset, then confirm, then confirm with op_sel=0 -> state 0->1->2, and input_start is high for exactly 1 cycle as state becomes 2. Then input_done -> state 7 with store_start=1 for 1 cycle. Then store_done -> state 1.
2. In INPUT, assert input_err and input_done in the same cycle -> state 6 for 1 cycle with err_code=1, then state 9 with countdown=3. Countdown steps 3->2->1 every 4 cycles, and after 12 cycles in WAIT state=1, countdown=0, err_code=0.
3. MENU with op_sel=3 -> SELECT. Confirm with operands_ok=0 -> ERROR, err_code=3. After the 12-cycle WAIT -> state 8 (retry path). Confirm with operands_ok=1 -> state 5 with comp_start pulse. comp_done -> state 4 with disp_start pulse. back -> state 1.
4. In WAIT, pulse btn_confirm and btn_back, and pulse comp_done -> no state change and no strobe; exit still occurs at cycle 12.
5. Assert rst during WAIT with countdown=2 -> next edge: state=0, countdown=0, err_code=0, all strobes 0. A subsequent confirm -> state 1.
6. In GEN, pulse comp_done and store_done (foreign pulses) -> state stays 3. gen_done and btn_back in the same cycle -> state 7 (done beats back).

Source files
------------

// File: rtl/matrix_ctrl_fsm.sv
// Top-level sequencer of the matrix calculator: start strobes, error handling, post-error countdown.
// All outputs registered and change on the same edge as state; no backpressure, inputs are one-cycle pulses.
module matrix_ctrl_fsm #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int WAIT_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_confirm,
  input  logic       btn_back,
  input  logic [1:0] op_sel,
  input  logic       input_done,
  input  logic       input_err,
  input  logic       gen_done,
  input  logic       store_done,
  input  logic       store_full,
  input  logic       operands_ok,
  input  logic       comp_done,
  input  logic       comp_err,
  output logic [3:0] state,
  output logic       input_start,
  output logic       gen_start,
  output logic       disp_start,
  output logic       comp_start,
  output logic       store_start,
  output logic [3:0] countdown,
  output logic [2:0] err_code
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_MENU    = 4'd1,
    S_INPUT   = 4'd2,
    S_GEN     = 4'd3,
    S_DISPLAY = 4'd4,
    S_COMPUTE = 4'd5,
    S_ERROR   = 4'd6,
    S_STORE   = 4'd7,
    S_SELECT  = 4'd8,
    S_WAIT    = 4'd9
  } state_t;

  localparam int             PW      = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(CLK_FREQ - 1);
  localparam logic [3:0]     CD_INIT = 4'(WAIT_SEC);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_INPUT   = 3'd1;
  localparam logic [2:0] ERR_FULL    = 3'd2;
  localparam logic [2:0] ERR_OPERAND = 3'd3;
  localparam logic [2:0] ERR_COMPUTE = 3'd4;

  state_t        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [3:0]    cd_q, cd_d;
  logic [2:0]    err_q, err_d;
  logic          retry_q, retry_d;
  logic [4:0]    strb_q, strb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ps_q    <= '0;
      cd_q    <= '0;
      err_q   <= ERR_NONE;
      retry_q <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      cd_q    <= cd_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ps_d    = '0;
    cd_d    = '0;
    err_d   = err_q;
    retry_d = retry_q;

    case (state_q)
      S_IDLE: begin
        if (btn_confirm) state_d = S_MENU;
      end
      S_MENU: begin
        if (btn_back) begin
          state_d = S_IDLE;
        end else if (btn_confirm) begin
          case (op_sel)
            2'd0:    state_d = S_INPUT;
            2'd1:    state_d = S_GEN;
            2'd2:    state_d = S_DISPLAY;
            default: state_d = S_SELECT;
          endcase
        end
      end
      S_INPUT: begin
        if (input_err) begin
          state_d = S_ERROR;
          err_d   = ERR_INPUT;
          retry_d = 1'b0;
        end else if (input_done) begin
          state_d = S_STORE;
        end else if (btn_back) begin
          state_d = S_MENU;
        end
      end
      S_GEN: begin
        if (gen_done)      state_d = S_STORE;
        else if (btn_back) state_d = S_MENU;
      end
      S_STORE: begin
        if (store_full) begin
          state_d = S_ERROR;
          err_d   = ERR_FULL;
          retry_d = 1'b0;
        end else if (store_done) begin
          state_d = S_MENU;
        end
      end
      S_DISPLAY: begin
        if (btn_back || btn_confirm) state_d = S_MENU;
      end
      S_SELECT: begin
        if (btn_back) begin
          state_d = S_MENU;
        end else if (btn_confirm) begin
          if (operands_ok) begin
            state_d = S_COMPUTE;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_OPERAND;
            retry_d = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (comp_err) begin
          state_d = S_ERROR;
          err_d   = ERR_COMPUTE;
          retry_d = 1'b1;
        end else if (comp_done) begin
          state_d = S_DISPLAY;
        end
      end
      S_ERROR: begin
        state_d = S_WAIT;
        cd_d    = CD_INIT;
      end
      S_WAIT: begin
        // buttons are deliberately ignored; only the prescaler moves this state
        cd_d = cd_q;
        if (ps_q == PS_LAST) begin
          if (cd_q <= 4'd1) begin
            cd_d    = '0;
            err_d   = ERR_NONE;
            state_d = retry_q ? S_SELECT : S_MENU;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end else begin
          ps_d = ps_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = ERR_NONE;
        retry_d = 1'b0;
      end
    endcase

    strb_d = {(state_d == S_INPUT)   && (state_q != S_INPUT),
              (state_d == S_GEN)     && (state_q != S_GEN),
              (state_d == S_DISPLAY) && (state_q != S_DISPLAY),
              (state_d == S_COMPUTE) && (state_q != S_COMPUTE),
              (state_d == S_STORE)   && (state_q != S_STORE)};
  end

  assign state       = state_q;
  assign input_start = strb_q[4];
  assign gen_start   = strb_q[3];
  assign disp_start  = strb_q[2];
  assign comp_start  = strb_q[1];
  assign store_start = strb_q[0];
  assign countdown   = cd_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_matrix_ctrl_fsm.sv
// Scoreboarded bench for matrix_ctrl_fsm with CLK_FREQ=4, WAIT_SEC=3.
module tb_matrix_ctrl_fsm;

  localparam logic [4:0] NO   = 5'b00000;
  localparam logic [4:0] S_IN = 5'b10000;
  localparam logic [4:0] S_GN = 5'b01000;
  localparam logic [4:0] S_DS = 5'b00100;
  localparam logic [4:0] S_CP = 5'b00010;
  localparam logic [4:0] S_ST = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_confirm = 1'b0, btn_back = 1'b0;
  logic [1:0] op_sel = 2'd0;
  logic       input_done = 1'b0, input_err = 1'b0, gen_done = 1'b0;
  logic       store_done = 1'b0, store_full = 1'b0, operands_ok = 1'b0;
  logic       comp_done = 1'b0, comp_err = 1'b0;
  logic [3:0] state, countdown;
  logic       input_start, gen_start, disp_start, comp_start, store_start;
  logic [2:0] err_code;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  matrix_ctrl_fsm #(.CLK_FREQ(4), .WAIT_SEC(3)) dut (
    .clk(clk), .rst(rst),
    .btn_confirm(btn_confirm), .btn_back(btn_back), .op_sel(op_sel),
    .input_done(input_done), .input_err(input_err), .gen_done(gen_done),
    .store_done(store_done), .store_full(store_full), .operands_ok(operands_ok),
    .comp_done(comp_done), .comp_err(comp_err),
    .state(state),
    .input_start(input_start), .gen_start(gen_start), .disp_start(disp_start),
    .comp_start(comp_start), .store_start(store_start),
    .countdown(countdown), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d strb=%b cd=%0d ec=%0d, want st=%0d strb=%b cd=%0d ec=%0d",
               tag, got[15:12], got[11:7], got[6:3], got[2:0],
               exp[15:12], exp[11:7], exp[6:3], exp[2:0]);
    end
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare.
  task automatic tick(input string tag, input logic [3:0] st, input logic [4:0] strb,
                      input logic [3:0] cd, input logic [2:0] ec);
    logic [15:0] got;
    logic [15:0] exp;
    string       t;
    exp_q.push_back({st, strb, cd, ec});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    btn_confirm = 1'b0; btn_back = 1'b0;
    input_done = 1'b0; input_err = 1'b0; gen_done = 1'b0;
    store_done = 1'b0; store_full = 1'b0; comp_done = 1'b0; comp_err = 1'b0;
    got = {state, input_start, gen_start, disp_start, comp_start, store_start, countdown, err_code};
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    check(t, got, exp);
  endtask

  // Caller has just observed the first WAIT cycle (countdown=3); run the remaining 11 and the exit.
  task automatic run_wait(input string tag, input logic [2:0] ec, input logic [3:0] exit_st,
                          input bit poke);
    for (int k = 1; k < 12; k++) begin
      if (poke) begin
        if (k == 2 || k == 9) btn_confirm = 1'b1;
        if (k == 5 || k == 9) btn_back = 1'b1;
        if (k == 7) begin comp_done = 1'b1; store_done = 1'b1; end
      end
      tick(tag, 4'd9, NO, 4'(3 - k / 4), ec);
    end
    tick({tag, "_exit"}, exit_st, NO, 4'd0, 3'd0);
  endtask

  initial begin
    // 1: reset, menu, input, store
    tick("reset", 4'd0, NO, 4'd0, 3'd0);
    rst = 1'b0;
    tick("idle_hold", 4'd0, NO, 4'd0, 3'd0);
    btn_confirm = 1'b1;
    tick("to_menu", 4'd1, NO, 4'd0, 3'd0);
    op_sel = 2'd0; btn_confirm = 1'b1;
    tick("to_input", 4'd2, S_IN, 4'd0, 3'd0);
    tick("input_strobe_off", 4'd2, NO, 4'd0, 3'd0);
    input_done = 1'b1;
    tick("to_store", 4'd7, S_ST, 4'd0, 3'd0);
    btn_back = 1'b1;
    tick("store_ignores_back", 4'd7, NO, 4'd0, 3'd0);
    store_done = 1'b1;
    tick("store_to_menu", 4'd1, NO, 4'd0, 3'd0);

    // 3+4: operand mismatch, retry path with buttons poked during WAIT
    op_sel = 2'd3; btn_confirm = 1'b1;
    tick("to_select", 4'd8, NO, 4'd0, 3'd0);
    operands_ok = 1'b0; btn_confirm = 1'b1;
    tick("mismatch_err", 4'd6, NO, 4'd0, 3'd3);
    tick("mismatch_wait", 4'd9, NO, 4'd3, 3'd3);
    run_wait("wait_op", 3'd3, 4'd8, 1'b1);
    operands_ok = 1'b1; btn_confirm = 1'b1;
    tick("to_compute", 4'd5, S_CP, 4'd0, 3'd0);
    comp_done = 1'b1;
    tick("to_display", 4'd4, S_DS, 4'd0, 3'd0);
    btn_back = 1'b1;
    tick("display_back", 4'd1, NO, 4'd0, 3'd0);

    // compute fault also retries
    op_sel = 2'd3; btn_confirm = 1'b1;
    tick("to_select2", 4'd8, NO, 4'd0, 3'd0);
    btn_confirm = 1'b1;
    tick("to_compute2", 4'd5, S_CP, 4'd0, 3'd0);
    comp_err = 1'b1; comp_done = 1'b1; btn_back = 1'b1;
    tick("comp_err", 4'd6, NO, 4'd0, 3'd4);
    tick("comp_wait", 4'd9, NO, 4'd3, 3'd4);
    run_wait("wait_comp", 3'd4, 4'd8, 1'b0);
    btn_back = 1'b1; btn_confirm = 1'b1;
    tick("select_back", 4'd1, NO, 4'd0, 3'd0);

    // 2: input error beats done; retry flag now clear so exit goes to MENU
    op_sel = 2'd0; btn_confirm = 1'b1;
    tick("to_input2", 4'd2, S_IN, 4'd0, 3'd0);
    input_err = 1'b1; input_done = 1'b1;
    tick("input_err", 4'd6, NO, 4'd0, 3'd1);
    tick("input_wait", 4'd9, NO, 4'd3, 3'd1);
    run_wait("wait_in", 3'd1, 4'd1, 1'b0);

    // 6: foreign pulses in GEN, done beats back, then store full
    op_sel = 2'd1; btn_confirm = 1'b1;
    tick("to_gen", 4'd3, S_GN, 4'd0, 3'd0);
    comp_done = 1'b1;
    tick("gen_foreign_comp", 4'd3, NO, 4'd0, 3'd0);
    store_done = 1'b1; input_done = 1'b1;
    tick("gen_foreign_store", 4'd3, NO, 4'd0, 3'd0);
    gen_done = 1'b1; btn_back = 1'b1;
    tick("gen_done_beats_back", 4'd7, S_ST, 4'd0, 3'd0);
    store_full = 1'b1; store_done = 1'b1;
    tick("store_full", 4'd6, NO, 4'd0, 3'd2);
    tick("full_wait", 4'd9, NO, 4'd3, 3'd2);
    run_wait("wait_full", 3'd2, 4'd1, 1'b0);

    // display entered and left by confirm
    op_sel = 2'd2; btn_confirm = 1'b1;
    tick("to_display2", 4'd4, S_DS, 4'd0, 3'd0);
    btn_confirm = 1'b1;
    tick("display_confirm", 4'd1, NO, 4'd0, 3'd0);

    // 5: reset in mid-WAIT with countdown=2
    op_sel = 2'd0; btn_confirm = 1'b1;
    tick("to_input3", 4'd2, S_IN, 4'd0, 3'd0);
    input_err = 1'b1;
    tick("input_err3", 4'd6, NO, 4'd0, 3'd1);
    tick("rst_wait0", 4'd9, NO, 4'd3, 3'd1);
    for (int k = 1; k <= 4; k++) tick("rst_wait", 4'd9, NO, 4'(3 - k / 4), 3'd1);
    rst = 1'b1;
    tick("rst_mid_wait", 4'd0, NO, 4'd0, 3'd0);
    rst = 1'b0; btn_confirm = 1'b1;
    tick("after_rst_menu", 4'd1, NO, 4'd0, 3'd0);
    btn_back = 1'b1; btn_confirm = 1'b1;
    tick("menu_back_beats_confirm", 4'd0, NO, 4'd0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
